sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WORD_SIZE, 16, data width of the shared SRAM.
REQ-002 Parameter ADDR_SIZE, 8, address width (256 words).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mN_req  input  1  access request from requester N (N=0,1); held high until mN_done.
REQ-006 mN_we  input  1  1=write, 0=read; stable while mN_req high.
REQ-007 mN_addr  input  ADDR_SIZE  word address; stable while mN_req high.
REQ-008 mN_wdata  input  WORD_SIZE  write data; stable while mN_req high.
REQ-009 mN_gnt  output  1  high while requester N owns the SRAM (ACCESS and RESP).
REQ-010 mN_done  output  1  one-cycle completion strobe for requester N.
REQ-011 mN_rdata  output  WORD_SIZE  read data; equals mem_rdata when mN_done=1, else 0.
REQ-012 mem_en  output  1  SRAM cycle enable.
REQ-013 mem_we  output  1  SRAM write enable.
REQ-014 mem_addr  output  ADDR_SIZE  SRAM address.
REQ-015 mem_wdata  output  WORD_SIZE  SRAM write data.
REQ-016 mem_rdata  input  WORD_SIZE  SRAM synchronous read data, valid the cycle after mem_en.

Function
REQ-017 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-018 IDLE: no request -> stay IDLE; any mN_req high -> ACCESS next edge, winner's we/addr/wdata registered at that edge.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both requesting -> port other than last_served wins.
REQ-020 last_served SHALL update to the winner on the IDLE->ACCESS edge.
REQ-021 ACCESS (one cycle): mem_en=1, mem_we/mem_addr/mem_wdata = registered winner values; always -> RESP.
REQ-022 RESP (one cycle): mem_en=0; winner's mN_done=1 (combinational from state), mN_rdata=mem_rdata; always -> IDLE.
REQ-023 mN_gnt SHALL be high for the winner in ACCESS and RESP only; never both ports simultaneously.
REQ-024 Writes SHALL also complete with mN_done in RESP; mN_rdata then carries mem_rdata and is don't-care to requester.
REQ-025 Latency: req sampled in IDLE cycle T -> ACCESS T+1 -> done T+2; next grant earliest T+3; peak throughput one access per 3 cycles.
REQ-026 Requester SHALL drop mN_req by the cycle after mN_done; a still-high req in IDLE is treated as a new request.
REQ-027 mN_req dropped during ACCESS/RESP SHALL NOT abort: access completes, done still pulses.
REQ-028 Input changes during ACCESS/RESP SHALL NOT alter mem_* outputs (registered copies used).
REQ-029 Address SHALL use full 0..2^ADDR_SIZE-1 range, no wrap or range check.
REQ-030 mem_we, mem_addr, mem_wdata SHALL be 0 whenever mem_en=0.

Reset
REQ-031 rst high SHALL immediately (asynchronously) force state IDLE, all outputs 0, registered copies 0, last_served=1 (port 0 wins first contention).
REQ-032 rst during ACCESS or RESP SHALL abort the access: mem_en drops at once, no mN_done issued; requester re-requests after release.

Verification
REQ-033 Reset/read: rst=1 -> all outputs 0; release, SRAM[0x01]=0x0008, m0 read 0x01 at T -> mem_en=1 mem_addr=0x01 at T+1, m0_done=1 m0_rdata=0x0008 at T+2.
REQ-034 Write then read: m1 write 0x05/0x7000 -> ACCESS shows mem_en=1 mem_we=1 mem_addr=0x05 mem_wdata=0x7000, m1_done next cycle; m0 read 0x05 -> m0_rdata=0x7000.
REQ-035 Contention: m0, m1 requesting from first IDLE after reset, each re-requesting after done -> grant order 0,1,0,1; m0_gnt and m1_gnt never high together.
REQ-036 Mid-op reset: rst=1 during ACCESS of m1 write -> mem_en=0 same cycle, no m1_done; after release with both requesting, m0 wins.
REQ-037 Starvation: m0_req held continuously, m1 raises req -> m1 granted at the next IDLE; m1_done within 6 cycles of m1_req.
REQ-038 Input stability: change m0_addr 0x10->0x20 during ACCESS -> mem_addr stays 0x10, m0_rdata = SRAM[0x10].

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Each granted access takes three cycles: IDLE (arbitrate), ACCESS (drive SRAM), RESP (done).
module sram_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_done,
    output logic [WORD_SIZE-1:0] m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_done,
    output logic [WORD_SIZE-1:0] m1_rdata,

    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 winner_q, winner_d;
    logic                 last_q, last_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 pick;
    logic                 busy;

    // Under contention the port not served last wins; otherwise the lone requester.
    assign pick = (m0_req && m1_req) ? ~last_q : m1_req;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d  = ACCESS;
                    winner_d = pick;
                    last_d   = pick;
                    we_d     = pick ? m1_we    : m0_we;
                    addr_d   = pick ? m1_addr  : m0_addr;
                    wdata_d  = pick ? m1_wdata : m0_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // All outputs decode from registered state so reset clears them immediately.
    assign busy      = (state_q == ACCESS) || (state_q == RESP);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign m0_gnt   = busy & ~winner_q;
    assign m1_gnt   = busy &  winner_q;
    assign m0_done  = (state_q == RESP) & ~winner_q;
    assign m1_done  = (state_q == RESP) &  winner_q;
    assign m0_rdata = m0_done ? mem_rdata : '0;
    assign m1_rdata = m1_done ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single transactions plus hand-written
// sequences for mid-access reset, contention, starvation and input stability.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [15:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] sram [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port SRAM model: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [7:0] addr, input logic [15:0] wdata);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Issue one request from IDLE; the request is dropped during ACCESS, which must not abort.
    task automatic run_vec(input vec_t v);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        check("acc_gnt_win",  v.port ? m1_gnt : m0_gnt, 1);
        check("acc_gnt_oth",  v.port ? m0_gnt : m1_gnt, 0);
        check("acc_mem_en",   mem_en, 1);
        check("acc_mem_we",   mem_we, v.we);
        check("acc_mem_addr", mem_addr, v.addr);
        check("acc_mem_wdata", mem_wdata, v.wdata);
        set_port(v.port, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        check("resp_done_win", v.port ? m1_done : m0_done, 1);
        check("resp_done_oth", v.port ? m0_done : m1_done, 0);
        check("resp_mem_off", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        if (!v.we) check("resp_rdata", v.port ? m1_rdata : m0_rdata, v.exp_rdata);
        @(negedge clk);
        check("idle_quiet", {m0_gnt, m1_gnt, m0_done, m1_done, mem_en}, 0);
    endtask

    initial begin
        int grants [$];
        int waited;
        logic seen;

        for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
        sram[8'h01] <= 16'h0008;
        sram[8'h10] <= 16'hABCD;
        sram[8'h20] <= 16'h1234;
        mem_rdata <= 16'h0000;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h01, wdata: 16'h0000, exp_rdata: 16'h0008};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h05, wdata: 16'h7000, exp_rdata: 16'h0000};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 8'h05, wdata: 16'h0000, exp_rdata: 16'h7000};
        vecs[3] = '{port: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 16'hBEEF, exp_rdata: 16'h0000};
        vecs[4] = '{port: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 16'h0000, exp_rdata: 16'hBEEF};
        vecs[5] = '{port: 1'b0, we: 1'b1, addr: 8'h00, wdata: 16'h1111, exp_rdata: 16'h0000};
        vecs[6] = '{port: 1'b1, we: 1'b0, addr: 8'h00, wdata: 16'h0000, exp_rdata: 16'h1111};

        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset_outputs", {m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
                                mem_en, mem_we, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of an m1 write: SRAM cycle disappears, no done, nothing written.
        set_port(1'b1, 1'b1, 1'b1, 8'h30, 16'h5555);
        @(negedge clk);
        check("mid_rst_acc_en", mem_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_en_drop", {mem_en, m1_gnt, mem_we, mem_addr}, 0);
        @(negedge clk);
        check("mid_rst_no_done", {m0_done, m1_done}, 0);
        check("mid_rst_no_write", sram[8'h30], 16'h0000);

        // Release with both requesting: m0 must win first, then strict alternation.
        rst = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
        set_port(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("gnt_exclusive", {31'd0, m0_gnt & m1_gnt}, 0);
            if (mem_en) grants.push_back(m1_gnt ? 1 : 0);
        end
        check("contention_count", grants.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < grants.size()) check("contention_order", grants[k], k % 2);
        end
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);

        // m0 holds req continuously; m1 raised during m0's ACCESS must still be served.
        set_port(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        @(negedge clk);
        check("starve_m0_first", m0_gnt, 1);
        set_port(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000);
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 8) begin
            @(negedge clk);
            waited++;
            check("starve_exclusive", {31'd0, m0_gnt & m1_gnt}, 0);
            if (m1_done) begin
                seen = 1'b1;
                check("starve_m1_rdata", m1_rdata, 16'h1234);
            end
        end
        check("starve_m1_done_seen", {31'd0, seen}, 1);
        check("starve_within_6", {31'd0, waited <= 6}, 1);
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);
        check("starve_idle", {m0_gnt, m1_gnt, mem_en}, 0);

        // Address changed mid-access must not leak to the SRAM.
        set_port(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        @(negedge clk);
        check("stab_addr_before", mem_addr, 8'h10);
        m0_addr = 8'h20;
        #1;
        check("stab_addr_after", mem_addr, 8'h10);
        @(negedge clk);
        check("stab_done", m0_done, 1);
        check("stab_rdata", m0_rdata, 16'hABCD);
        set_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
